ahb_mem_slave: RTL and testbench

//  AHB-Lite memory slave: the DUT the driver/monitor interface bundle connects to.
//  - Decodes address phases.
//  - Inserts programmable wait states.
//  - Performs byte/halfword/word reads and writes to a word-organised memory.
//  - Returns the two-cycle ERROR response on illegal transfers.

---
 rtl/ahb_pkg.sv | 40 ++++
 rtl/ahb_slv_mem.sv | 33 +++
 rtl/ahb_mem_slave.sv | 136 +++++++++++++
 tb/tb_ahb_mem_slave.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response constants and the byte-lane strobe helper
// used by the memory slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;

  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] strb;
    strb = 4'b0000;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr;
      SIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: strb = 4'b1111;
      default:   strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// Word-organised storage with per-byte write strobes; read data is registered
// and holds its value until the next read enable.
module ahb_slv_mem
  import ahb_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic [3:0]    wr_strb,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [MEM_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_strb[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: decode, wait-state FSM, two-cycle ERROR and write forwarding.
// Optional read-only low region enabled by defining AHB_SLV_RO_REGION_EN.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0,
  parameter int RO_WORDS    = 16
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);
  localparam logic [3:0]  WS         = 4'(WAIT_STATES);

  slv_state_e    state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic [AW+1:0] addr_q;
  logic [2:0]    size_q;
  logic          write_q, pend_q;
  logic          addr_phase, misaligned, ro_hit, legal, rd_en;
  logic [3:0]    wr_strb, fwd_strb;
  logic [31:0]   fwd_data, mem_rdata;
  logic          unused_inputs;

  assign unused_inputs = ^{hburst, hprot};

`ifdef AHB_SLV_RO_REGION_EN
  assign ro_hit = hwrite && (haddr[31:2] < 30'(RO_WORDS));
`else
  logic unused_ro;
  assign unused_ro = (RO_WORDS != 0);
  assign ro_hit    = 1'b0;
`endif

  assign hready = !((state == ST_ERR1) || ((state == ST_WAIT) && (cnt != 4'd0)));
  assign hresp  = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  assign addr_phase = hsel && ((htrans == TRANS_NONSEQ) || (htrans == TRANS_SEQ)) && hready;
  assign misaligned = ((hsize == SIZE_HALF) && haddr[0]) ||
                      ((hsize == SIZE_WORD) && (haddr[1:0] != 2'b00));
  assign legal      = (haddr < ADDR_LIMIT) && (hsize <= SIZE_WORD) && !misaligned && !ro_hit;
  assign rd_en      = addr_phase && legal && !hwrite;

  // Gated by reset so a write whose data phase ends on a reset edge is dropped.
  assign wr_strb = (hresetn && pend_q && write_q && hready) ?
                   byte_lanes(size_q, addr_q[1:0]) : 4'b0000;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (state == ST_WAIT && cnt != 4'd0) cnt_d = cnt - 4'd1;
    if (state == ST_ERR1) state_d = ST_ERR2;
    if (hready) begin
      if (addr_phase) begin
        if (!legal) begin
          state_d = ST_ERR1;
        end else if (WS != 4'd0) begin
          state_d = ST_WAIT;
          cnt_d   = WS;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (hready) pend_q <= addr_phase && legal;
      if (addr_phase) begin
        addr_q  <= haddr[AW+1:0];
        size_q  <= hsize;
        write_q <= hwrite;
      end
    end
  end

  // A read sampled on the edge where a write to the same word completes sees
  // the pre-write array word; remember the written lanes and merge them in.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      fwd_strb <= 4'b0000;
      fwd_data <= '0;
    end else if (rd_en) begin
      fwd_strb <= (addr_q[AW+1:2] == haddr[AW+1:2]) ? wr_strb : 4'b0000;
      fwd_data <= hwdata;
    end
  end

  always_comb begin
    hrdata = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (fwd_strb[i]) hrdata[8*i +: 8] = fwd_data[8*i +: 8];
    end
  end

  ahb_slv_mem #(
    .MEM_WORDS(MEM_WORDS),
    .AW       (AW)
  ) u_mem (
    .clk    (hclk),
    .rst_n  (hresetn),
    .rd_en  (rd_en),
    .rd_addr(haddr[AW+1:2]),
    .wr_strb(wr_strb),
    .wr_addr(addr_q[AW+1:2]),
    .wr_data(hwdata),
    .rd_data(mem_rdata)
  );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: two instances (zero and three wait states) on a shared
// bus with per-instance hsel, driven from a directed vector table plus corner sequences.
module tb_ahb_mem_slave;

  logic        clk = 1'b0;
  logic        hresetn;
  logic [1:0]  hsel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [31:0] hrdata0, hrdata1;
  logic        hready0, hready1, hresp0, hresp1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahb_mem_slave #(.MEM_WORDS(1024), .WAIT_STATES(0), .RO_WORDS(2)) dut0 (
    .hclk(clk), .hresetn(hresetn), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
  );

  ahb_mem_slave #(.MEM_WORDS(1024), .WAIT_STATES(3), .RO_WORDS(2)) dut1 (
    .hclk(clk), .hresetn(hresetn), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata1), .hready(hready1), .hresp(hresp1)
  );

  typedef struct {
    int          w;
    logic        wr;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        exp_err;
    int          exp_low;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int w, logic wr, logic [31:0] a, logic [2:0] sz, logic [31:0] wd,
                              logic exp_err, int exp_low, logic chk_rd, logic [31:0] exp_rd);
    vec_t v;
    v.w = w; v.wr = wr; v.a = a; v.sz = sz; v.wd = wd;
    v.exp_err = exp_err; v.exp_low = exp_low; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(int w);
    return (w != 0) ? hready1 : hready0;
  endfunction

  function automatic logic rsp(int w);
    return (w != 0) ? hresp1 : hresp0;
  endfunction

  function automatic logic [31:0] rdat(int w);
    return (w != 0) ? hrdata1 : hrdata0;
  endfunction

  task automatic bus_idle();
    hsel = 2'b00; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd2; haddr = '0;
  endtask

  // Single non-pipelined transfer; called just after a posedge with the slave ready.
  task automatic xfer(input int w, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] resp,
                      output int low);
    logic done;
    hsel      = 2'b00;
    hsel[w]   = 1'b1;
    htrans    = 2'd2;
    haddr     = a;
    hwrite    = wr;
    hsize     = sz;
    @(posedge clk); #1;
    bus_idle();
    hwdata = wd;
    low = 0; resp = 2'b00; done = 1'b0; rd = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (rdy(w)) begin
        done    = 1'b1;
        resp[0] = rsp(w);
        rd      = rdat(w);
      end else begin
        low++;
        if (rsp(w)) resp[1] = 1'b1;
      end
    end
    if (!done) check("xfer_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd, old;
  logic [1:0]  resp;
  int          low, bubbles;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(0, 1, 32'h10,   3'd2, 32'hDEADBEEF, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h10,   3'd2, 32'h0,        0, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 32'h10,   3'd2, 32'h11223344, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h13,   3'd0, 32'hAA000000, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h10,   3'd2, 32'h0,        0, 0, 1, 32'hAA223344));
    vecs.push_back(mk(0, 1, 32'h12,   3'd1, 32'h55660000, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h10,   3'd2, 32'h0,        0, 0, 1, 32'h55663344));
    vecs.push_back(mk(0, 0, 32'h2,    3'd2, 32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h10,   3'd2, 32'h0,        0, 0, 1, 32'h55663344));
    vecs.push_back(mk(0, 1, 32'h1000, 3'd2, 32'hFFFFFFFF, 1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'hFFC,  3'd2, 32'hCAFEF00D, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'hFFC,  3'd2, 32'h0,        0, 0, 1, 32'hCAFEF00D));
    vecs.push_back(mk(0, 1, 32'h11,   3'd1, 32'h0000BEEF, 1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h10,   3'd3, 32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h10,   3'd2, 32'h0,        0, 0, 1, 32'h55663344));
    vecs.push_back(mk(0, 0, 32'h0,    3'd2, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h20,   3'd2, 32'h12345678, 0, 3, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h20,   3'd2, 32'h0,        0, 3, 1, 32'h12345678));
    vecs.push_back(mk(1, 0, 32'h2,    3'd2, 32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h1000, 3'd2, 32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h20,   3'd2, 32'h0,        0, 3, 1, 32'h12345678));

    hburst = 3'd0; hprot = 4'd0; hwdata = '0;
    bus_idle();
    hresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 hresetn = 1'b1;
    @(negedge clk);
    check("rst_hready0", {31'd0, hready0}, 32'd1);
    check("rst_hresp0",  {31'd0, hresp0},  32'd0);
    check("rst_hrdata0", hrdata0,          32'd0);
    check("rst_hready1", {31'd0, hready1}, 32'd1);
    check("rst_hresp1",  {31'd0, hresp1},  32'd0);
    check("rst_hrdata1", hrdata1,          32'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      xfer(vecs[i].w, vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].wd, rd, resp, low);
      check($sformatf("v%0d_resp", i), {30'd0, resp}, vecs[i].exp_err ? 32'd3 : 32'd0);
      check($sformatf("v%0d_low", i), low, vecs[i].exp_low);
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Pipelined back-to-back transfers with write forwarding on dut0.
    bubbles = 0;
    hsel = 2'b01; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
    @(negedge clk); if (!hready0) bubbles++;
    @(posedge clk); #1;
    htrans = 2'd3; hwrite = 1'b0; haddr = 32'h40; hwdata = 32'hA5A5A5A5;
    @(negedge clk); if (!hready0) bubbles++;
    @(posedge clk); #1;
    htrans = 2'd2; hwrite = 1'b1; hsize = 3'd0; haddr = 32'h41;
    @(negedge clk); if (!hready0) bubbles++;
    check("pipe_fwd_word", hrdata0, 32'hA5A5A5A5);
    @(posedge clk); #1;
    htrans = 2'd2; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h40; hwdata = 32'h00007700;
    @(negedge clk); if (!hready0) bubbles++;
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk); if (!hready0) bubbles++;
    check("pipe_fwd_byte", hrdata0, 32'hA5A577A5);
    check("pipe_bubbles", bubbles, 0);
    @(posedge clk); #1;
    xfer(0, 0, 32'h40, 3'd2, 32'h0, rd, resp, low);
    check("pipe_mem_after", rd, 32'hA5A577A5);

    // Read-only low region (or plain write when the feature is off).
    xfer(0, 0, 32'h0, 3'd2, 32'h0, old, resp, low);
    xfer(0, 1, 32'h0, 3'd2, 32'h00000001, rd, resp, low);
`ifdef AHB_SLV_RO_REGION_EN
    check("ro_write_resp", {30'd0, resp}, 32'd3);
    check("ro_write_low", low, 1);
    xfer(0, 0, 32'h0, 3'd2, 32'h0, rd, resp, low);
    check("ro_read_resp", {30'd0, resp}, 32'd0);
    check("ro_read_data", rd, old);
`else
    check("rw_write_resp", {30'd0, resp}, 32'd0);
    check("rw_write_low", low, 0);
    xfer(0, 0, 32'h0, 3'd2, 32'h0, rd, resp, low);
    check("rw_read_resp", {30'd0, resp}, 32'd0);
    check("rw_read_data", rd, 32'h00000001);
`endif

    // Reset during a wait-state write on dut1 drops the write.
    xfer(1, 1, 32'h30, 3'd2, 32'h11111111, rd, resp, low);
    hsel = 2'b10; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h30;
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'h22222222;
    @(negedge clk);
    check("midrst_stalled", {31'd0, hready1}, 32'd0);
    hresetn = 1'b0;
    @(posedge clk); #1;
    hresetn = 1'b1;
    @(negedge clk);
    check("midrst_hready", {31'd0, hready1}, 32'd1);
    check("midrst_hresp",  {31'd0, hresp1},  32'd0);
    check("midrst_hrdata", hrdata1,          32'd0);
    @(posedge clk); #1;
    xfer(1, 0, 32'h30, 3'd2, 32'h0, rd, resp, low);
    check("midrst_data", rd, 32'h11111111);
    check("midrst_low", low, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
